// File: rtl/sprite_blitter_pkg.sv
// Shared types and constants for the sprite blitter: FSM encoding, screen geometry,
// colour palette (including the default transparent key) and the pipeline slot record.
package sprite_blitter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } blit_state_t;

    localparam int SCREEN_W_DEF = 320;
    localparam int SCREEN_H_DEF = 240;
    localparam int COLOUR_W_DEF = 3;

    localparam logic [2:0] COL_BLACK   = 3'b000;
    localparam logic [2:0] COL_BLUE    = 3'b001;
    localparam logic [2:0] COL_GREEN   = 3'b010;
    localparam logic [2:0] COL_CYAN    = 3'b011;
    localparam logic [2:0] COL_RED     = 3'b100;
    localparam logic [2:0] COL_MAGENTA = 3'b101;
    localparam logic [2:0] COL_YELLOW  = 3'b110;
    localparam logic [2:0] COL_WHITE   = 3'b111;
    localparam logic [2:0] TRANSP_KEY  = COL_WHITE;

    // One pixel slot travelling alongside the ROM read; sums are one bit wider than the screen bus.
    typedef struct packed {
        logic       valid;
        logic [9:0] x;
        logic [8:0] y;
    } slot_t;

    // Counter width that still works for a dimension of 1.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sprite_scan_gen.sv
// Row-major pixel scanner: column/row counters, row-base accumulator (no multiplier)
// and the optionally mirrored ROM address for the current slot.
module sprite_scan_gen
    import sprite_blitter_pkg::*;
#(
    parameter int SPR_W    = 70,
    parameter int SPR_H    = 71,
    parameter int ADDR_W   = 13,
    parameter int COL_BITS = 7,
    parameter int ROW_BITS = 7
)(
    input  logic                clk,
    input  logic                srst,
    input  logic                clear,
    input  logic                advance,
    input  logic                flip,
    output logic [COL_BITS-1:0] col,
    output logic [ROW_BITS-1:0] row,
    output logic [ADDR_W-1:0]   addr,
    output logic                last
);

    localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(SPR_W - 1);
    localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(SPR_H - 1);
    localparam logic [ADDR_W-1:0]   W_STEP   = ADDR_W'(SPR_W);

    logic [COL_BITS-1:0] col_reg;
    logic [ROW_BITS-1:0] row_reg;
    logic [ADDR_W-1:0]   base_reg;
    logic [COL_BITS-1:0] col_eff;
    logic                col_end;
    logic                row_end;

    assign col_end = (col_reg == COL_LAST);
    assign row_end = (row_reg == ROW_LAST);

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            col_reg  <= '0;
            row_reg  <= '0;
            base_reg <= '0;
        end else if (advance) begin
            if (col_end) begin
                col_reg <= '0;
                // Wrap fully after the last slot so the next draw starts from a clean origin.
                if (row_end) begin
                    row_reg  <= '0;
                    base_reg <= '0;
                end else begin
                    row_reg  <= row_reg + 1'b1;
                    base_reg <= base_reg + W_STEP;
                end
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

    assign col_eff = flip ? (COL_LAST - col_reg) : col_reg;
    assign addr    = base_reg + ADDR_W'(col_eff);
    assign col     = col_reg;
    assign row     = row_reg;
    assign last    = col_end & row_end;

endmodule

// File: rtl/sprite_blitter.sv
// Streams a SPR_W x SPR_H sprite from an external ROM to the VGA plot port with
// latency alignment, transparency skip, horizontal flip and screen-edge clipping.
module sprite_blitter
    import sprite_blitter_pkg::*;
#(
    parameter int                  SPR_W      = 70,
    parameter int                  SPR_H      = 71,
    parameter int                  ADDR_W     = 13,
    parameter int                  COLOUR_W   = COLOUR_W_DEF,
    parameter int                  ROM_LAT    = 1,
    parameter int                  TRANSP_EN  = 1,
    parameter logic [COLOUR_W-1:0] TRANSP_COL = COLOUR_W'(TRANSP_KEY),
    parameter int                  SCREEN_W   = SCREEN_W_DEF,
    parameter int                  SCREEN_H   = SCREEN_H_DEF
)(
    input  logic                clock_all,
    input  logic                reset_all,
    input  logic                start,
    input  logic [8:0]          x_,
    input  logic [7:0]          y_,
    input  logic                flip_h,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_q,
    output logic [8:0]          out_x,
    output logic [7:0]          out_y,
    output logic [COLOUR_W-1:0] out_colour,
    output logic                plot
);

    localparam int         COL_BITS   = clog2_min1(SPR_W);
    localparam int         ROW_BITS   = clog2_min1(SPR_H);
    localparam logic [1:0] DRAIN_LAST = 2'(ROM_LAT - 1);

    blit_state_t         state_reg;
    logic                busy_reg;
    logic                done_reg;
    logic [1:0]          drain_cnt_reg;
    logic [8:0]          x0_reg;
    logic [7:0]          y0_reg;
    logic                flip_reg;

    logic                start_ok;
    logic [COL_BITS-1:0] scan_col;
    logic [ROW_BITS-1:0] scan_row;
    logic                scan_last;

    slot_t               s0;
    slot_t               tap;
    logic                in_screen;
    logic                is_transp;

    logic [8:0]          out_x_reg;
    logic [7:0]          out_y_reg;
    logic [COLOUR_W-1:0] out_colour_reg;
    logic                plot_reg;

    // busy stays up through the done cycle, so gating on it also blocks a start there.
    assign start_ok = start && (state_reg == ST_IDLE) && !busy_reg;

    sprite_scan_gen #(
        .SPR_W    (SPR_W),
        .SPR_H    (SPR_H),
        .ADDR_W   (ADDR_W),
        .COL_BITS (COL_BITS),
        .ROW_BITS (ROW_BITS)
    ) u_scan (
        .clk     (clock_all),
        .srst    (reset_all),
        .clear   (start_ok),
        .advance (state_reg == ST_SCAN),
        .flip    (flip_reg),
        .col     (scan_col),
        .row     (scan_row),
        .addr    (rom_addr),
        .last    (scan_last)
    );

    always_ff @(posedge clock_all) begin
        if (reset_all) begin
            state_reg     <= ST_IDLE;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            drain_cnt_reg <= '0;
            x0_reg        <= '0;
            y0_reg        <= '0;
            flip_reg      <= 1'b0;
        end else begin
            // done is the registered image of DONE, landing one cycle after the last plot.
            done_reg <= (state_reg == ST_DONE);
            if (done_reg) begin
                busy_reg <= 1'b0;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (start_ok) begin
                        state_reg <= ST_SCAN;
                        busy_reg  <= 1'b1;
                        x0_reg    <= x_;
                        y0_reg    <= y_;
                        flip_reg  <= flip_h;
                    end
                end
                ST_SCAN: begin
                    if (scan_last) begin
                        drain_cnt_reg <= '0;
                        state_reg     <= (ROM_LAT == 0) ? ST_DONE : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_reg == DRAIN_LAST) begin
                        state_reg <= ST_DONE;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + 2'd1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        s0       = '0;
        s0.valid = (state_reg == ST_SCAN);
        s0.x     = 10'(x0_reg) + 10'(scan_col);
        s0.y     = 9'(y0_reg) + 9'(scan_row);
    end

    // Delay the slot record by ROM_LAT cycles so it meets its rom_q word.
    generate
        if (ROM_LAT == 0) begin : g_nolat
            assign tap = s0;
        end else begin : g_lat
            slot_t dly [1:ROM_LAT];
            genvar gi;
            for (gi = 1; gi <= ROM_LAT; gi++) begin : g_stage
                if (gi == 1) begin : g_first
                    always_ff @(posedge clock_all) begin
                        if (reset_all) dly[gi] <= '0;
                        else           dly[gi] <= s0;
                    end
                end else begin : g_next
                    always_ff @(posedge clock_all) begin
                        if (reset_all) dly[gi] <= '0;
                        else           dly[gi] <= dly[gi-1];
                    end
                end
            end
            assign tap = dly[ROM_LAT];
        end
    endgenerate

    // The wide sums catch both off-screen pixels and wrap past the 9/8-bit bus.
    assign in_screen = (tap.x < 10'(SCREEN_W)) && (tap.y < 9'(SCREEN_H));
    assign is_transp = (TRANSP_EN != 0) && (rom_q == TRANSP_COL);

    always_ff @(posedge clock_all) begin
        if (reset_all) begin
            out_x_reg      <= '0;
            out_y_reg      <= '0;
            out_colour_reg <= '0;
            plot_reg       <= 1'b0;
        end else begin
            plot_reg <= tap.valid && in_screen && !is_transp;
            if (tap.valid) begin
                out_x_reg      <= tap.x[8:0];
                out_y_reg      <= tap.y[7:0];
                out_colour_reg <= rom_q;
            end
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign out_x      = out_x_reg;
    assign out_y      = out_y_reg;
    assign out_colour = out_colour_reg;
    assign plot       = plot_reg;

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter (4x3 sprite, ROM latency 1) against a
// pixel-list reference model built directly from the sprite/origin/clip rules.
module tb_sprite_blitter;

    localparam int W        = 4;
    localparam int H        = 3;
    localparam int N        = W * H;
    localparam int LAT      = 1;
    localparam int DONE_OFF = N + LAT + 2;
    localparam int HORIZON  = DONE_OFF + 4;

    logic        clk;
    logic        reset_all;
    logic        start;
    logic [8:0]  x_;
    logic [7:0]  y_;
    logic        flip_h;
    logic        busy;
    logic        done;
    logic [12:0] rom_addr;
    logic [2:0]  rom_q;
    logic [8:0]  out_x;
    logic [7:0]  out_y;
    logic [2:0]  out_colour;
    logic        plot;

    logic [2:0]  rom_mem [0:15];

    typedef struct {
        int x;
        int y;
        int col;
        int off;
    } ev_t;

    typedef struct {
        int x0;
        int y0;
        bit flip;
        int rom_kind;
        int exp_plots;
        int exp_done;
    } vec_t;

    ev_t  obs_q[$];
    ev_t  exp_q[$];
    vec_t vecs [0:6];

    int n_cmp = 0;
    int n_err = 0;
    int addr_err;
    int busy_err;
    int n_done;
    int done_off;

    sprite_blitter #(
        .SPR_W   (W),
        .SPR_H   (H),
        .ADDR_W  (13),
        .ROM_LAT (LAT)
    ) dut (
        .clock_all  (clk),
        .reset_all  (reset_all),
        .start      (start),
        .x_         (x_),
        .y_         (y_),
        .flip_h     (flip_h),
        .busy       (busy),
        .done       (done),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_colour (out_colour),
        .plot       (plot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clk) rom_q <= (rom_addr < 13'd16) ? rom_mem[rom_addr[3:0]] : 3'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fill_rom(input int kind);
        for (int i = 0; i < 16; i++) begin
            if (kind == 2) rom_mem[i] = 3'($urandom_range(0, 7));
            else           rom_mem[i] = 3'(i % 7);
        end
        if (kind == 1) begin
            rom_mem[5] = 3'd7;
            rom_mem[7] = 3'd7;
        end
    endtask

    // Reference: every sprite pixel, its source word, screen position and plot cycle.
    task automatic build_expected(input int x0, input int y0, input bit flip);
        exp_q.delete();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int src;
                int col;
                src = r * W + (flip ? (W - 1 - c) : c);
                col = int'(rom_mem[src]);
                if ((x0 + c) < 320 && (y0 + r) < 240 && col != 7)
                    exp_q.push_back('{x0 + c, y0 + r, col, r * W + c + LAT + 2});
            end
        end
    endtask

    function automatic int exp_addr(input int k, input bit flip);
        return flip ? ((k / W) * W + (W - 1 - (k % W))) : k;
    endfunction

    task automatic run_draw(input int x0, input int y0, input bit flip,
                            input int pulse1, input int pulse2);
        obs_q.delete();
        addr_err = 0;
        busy_err = 0;
        n_done   = 0;
        done_off = -1;
        @(negedge clk);
        x_ = 9'(x0); y_ = 8'(y0); flip_h = flip; start = 1'b1;
        @(negedge clk);
        start = 1'b0; x_ = 9'($urandom); y_ = 8'($urandom); flip_h = ~flip;
        for (int off = 1; off <= HORIZON; off++) begin
            if (plot === 1'b1) obs_q.push_back('{int'(out_x), int'(out_y), int'(out_colour), off});
            if (done === 1'b1) begin
                n_done++;
                done_off = off;
            end
            if (busy !== (off <= DONE_OFF)) busy_err++;
            if (off <= N && rom_addr !== 13'(exp_addr(off - 1, flip))) addr_err++;
            start = (off == pulse1 || off == pulse2);
            if (start) begin
                x_ = 9'd100; y_ = 8'd100; flip_h = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic compare_draw(input string tag);
        int n;
        check({tag, " plots"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s px%0d x", tag, i), obs_q[i].x, exp_q[i].x);
            check($sformatf("%s px%0d y", tag, i), obs_q[i].y, exp_q[i].y);
            check($sformatf("%s px%0d colour", tag, i), obs_q[i].col, exp_q[i].col);
            check($sformatf("%s px%0d cycle", tag, i), obs_q[i].off, exp_q[i].off);
        end
        check({tag, " done_cycle"}, done_off, DONE_OFF);
        check({tag, " done_pulses"}, n_done, 1);
        check({tag, " busy_errs"}, busy_err, 0);
        check({tag, " addr_errs"}, addr_err, 0);
    endtask

    initial begin
        int quiet;
        vecs[0] = '{10, 20, 1'b0, 0, 12, DONE_OFF};
        vecs[1] = '{10, 20, 1'b1, 0, 12, DONE_OFF};
        vecs[2] = '{10, 20, 1'b0, 1, 10, DONE_OFF};
        vecs[3] = '{318, 238, 1'b0, 0, 4, DONE_OFF};
        vecs[4] = '{319, 239, 1'b1, 0, 1, DONE_OFF};
        vecs[5] = '{511, 0, 1'b0, 0, 0, DONE_OFF};
        vecs[6] = '{0, 255, 1'b0, 0, 0, DONE_OFF};

        reset_all = 1'b1; start = 1'b0; x_ = '0; y_ = '0; flip_h = 1'b0;
        fill_rom(0);
        repeat (3) @(negedge clk);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst plot", plot, 0);
        check("rst rom_addr", rom_addr, 0);
        check("rst out_x", out_x, 0);
        check("rst out_y", out_y, 0);
        check("rst out_colour", out_colour, 0);
        reset_all = 1'b0;

        foreach (vecs[i]) begin
            fill_rom(vecs[i].rom_kind);
            build_expected(vecs[i].x0, vecs[i].y0, vecs[i].flip);
            run_draw(vecs[i].x0, vecs[i].y0, vecs[i].flip, 0, 0);
            check($sformatf("vec%0d plot_count", i), obs_q.size(), vecs[i].exp_plots);
            check($sformatf("vec%0d done_at", i), done_off, vecs[i].exp_done);
            compare_draw($sformatf("vec%0d", i));
            $display("vec%0d x=%0d y=%0d flip=%0d plots=%0d done@%0d", i, vecs[i].x0,
                     vecs[i].y0, vecs[i].flip, obs_q.size(), done_off);
        end

        // start re-pulsed mid-scan and during the done cycle must be ignored.
        fill_rom(0);
        build_expected(10, 20, 1'b0);
        run_draw(10, 20, 1'b0, 6, DONE_OFF);
        compare_draw("restart_ignored");
        $display("restart_ignored plots=%0d done_pulses=%0d", obs_q.size(), n_done);

        // Reset mid-scan aborts: quiet outputs and no done, then a clean redraw.
        @(negedge clk);
        x_ = 9'd10; y_ = 8'd20; flip_h = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset_all = 1'b1;
        @(negedge clk);
        check("abort plot", plot, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        reset_all = 1'b0;
        quiet = 0;
        for (int c = 0; c < 20; c++) begin
            if (plot !== 1'b0 || done !== 1'b0 || busy !== 1'b0) quiet++;
            @(negedge clk);
        end
        check("abort quiet_cycles", quiet, 0);
        build_expected(10, 20, 1'b0);
        run_draw(10, 20, 1'b0, 0, 0);
        compare_draw("post_abort");
        $display("post_abort plots=%0d done@%0d", obs_q.size(), done_off);

        for (int t = 0; t < 20; t++) begin
            int  rx;
            int  ry;
            bit  rf;
            rx = (t % 2) ? $urandom_range(300, 330) : $urandom_range(0, 511);
            ry = (t % 3) ? $urandom_range(225, 255) : $urandom_range(0, 255);
            rf = 1'($urandom_range(0, 1));
            fill_rom(2);
            build_expected(rx, ry, rf);
            run_draw(rx, ry, rf, 0, 0);
            compare_draw($sformatf("rand%0d", t));
            $display("rand%0d x=%0d y=%0d flip=%0d plots=%0d expected=%0d", t, rx, ry, rf,
                     obs_q.size(), exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
